// File: rtl/wbm_patch_master_pkg.sv
// Shared address-map definitions for the patch bus: region bases, the offset
// mask, the region enum and the beat address helper. The slave controller
// imports the same package, so both sides agree on the map.
package wbm_patch_master_pkg;

    localparam logic [31:0] WBS_BASE_MODE  = 32'h3000_0000; // MODE and DEBUG share
    localparam logic [31:0] WBS_BASE_QUERY = 32'h3100_0000;
    localparam logic [31:0] WBS_BASE_LEAF  = 32'h3200_0000;
    localparam logic [31:0] WBS_BASE_BEST  = 32'h3300_0000;
    localparam logic [31:0] WBS_BASE_NODE  = 32'h3400_0000;
    localparam logic [31:0] WBS_ADDR_MASK  = 32'h00FF_FFFF;

    typedef enum logic [2:0] {
        RGN_MODE  = 3'd0,
        RGN_DEBUG = 3'd1,
        RGN_QUERY = 3'd2,
        RGN_LEAF  = 3'd3,
        RGN_BEST  = 3'd4,
        RGN_NODE  = 3'd5
    } wb_region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_RESP
    } wbm_state_t;

    function automatic logic [31:0] region_base(input wb_region_t r);
        logic [31:0] b;
        case (r)
            RGN_QUERY: b = WBS_BASE_QUERY;
            RGN_LEAF:  b = WBS_BASE_LEAF;
            RGN_BEST:  b = WBS_BASE_BEST;
            RGN_NODE:  b = WBS_BASE_NODE;
            default:   b = WBS_BASE_MODE; // MODE, DEBUG and unused codes
        endcase
        return b;
    endfunction

    // Wide accesses use {index,beat} so a word pair sits at even/odd
    // addresses; offset bits above [23:0] are silently dropped.
    function automatic logic [31:0] beat_addr(input wb_region_t r, input logic [31:0] idx,
                                              input logic wide, input logic beat);
        logic [31:0] off;
        off = wide ? {idx[30:0], beat} : idx;
        return region_base(r) | (off & WBS_ADDR_MASK);
    endfunction

endpackage

// File: rtl/wbm_patch_master_if.sv
// Command / response stream plus Wishbone classic master bus of the patch
// loader. modport master is the initiator (wbm_patch_master); modport slave
// is the command source and bus target side.
//  cmd_*  : command in (valid/ready), we, region, wide, index, 64-bit wdata
//  rsp_*  : response out (valid/ready), 64-bit rdata, err (ack timeout)
//  wbm_*  : Wishbone classic cyc/stb/we/sel/adr/dat_o out, dat_i/ack in
interface wbm_patch_master_if #(
    parameter int IDX_W = 16
);
    import wbm_patch_master_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    wb_region_t       cmd_region;
    logic             cmd_wide;
    logic [IDX_W-1:0] cmd_index;
    logic [63:0]      cmd_wdata;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic [31:0]      wbm_dat_i;
    logic             wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_region, cmd_wide, cmd_index, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_region, cmd_wide, cmd_index, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wbm_patch_master.sv
// Wishbone classic single-transfer initiator for the accelerator slave map.
// Each accepted command becomes one 32-bit beat (narrow) or two beats,
// lower word at the even address then upper word at the odd address, with
// one mandatory idle cycle between them. One response per command.
//  wb_clk_i : clock
//  wb_rst_i : synchronous active-high reset
//  bus      : wbm_patch_master_if.master (command, response, Wishbone)
// Parameters: IDX_W (index width), TIMEOUT_CYCLES (ack wait limit, >=2).
module wbm_patch_master
    import wbm_patch_master_pkg::*;
#(
    parameter int IDX_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wbm_patch_master_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    wbm_state_t       state_q, state_d;
    logic             beat_q, beat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wide_q, wide_d;
    wb_region_t       region_q, region_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      hi_q, hi_d;        // upper write word, sent on beat1
    logic             ready_q, ready_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        wide_d      = wide_q;
        region_d    = region_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    wide_d   = bus.cmd_wide;
                    region_d = bus.cmd_region;
                    idx_d    = bus.cmd_index;
                    hi_d     = bus.cmd_wdata[63:32];
                    we_d     = bus.cmd_we;
                    beat_d   = 1'b0;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    cyc_d    = 1'b1;
                    adr_d    = beat_addr(bus.cmd_region, 32'(bus.cmd_index), bus.cmd_wide, 1'b0);
                    dat_d    = bus.cmd_we ? bus.cmd_wdata[31:0] : 32'h0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack is checked first so an ack on the final allowed cycle
                // still completes the beat without an error
                if (bus.wbm_ack_i) begin
                    cyc_d = 1'b0;
                    if (!we_q) begin
                        if (beat_q) rdata_d[63:32] = bus.wbm_dat_i;
                        else        rdata_d[31:0]  = bus.wbm_dat_i;
                    end
                    if (wide_q && !beat_q) begin
                        beat_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d       = 1'b0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // the slave needs this idle cycle before the odd-address beat
                cyc_d   = 1'b1;
                cnt_d   = '0;
                adr_d   = beat_addr(region_q, 32'(idx_q), wide_q, 1'b1);
                dat_d   = we_q ? hi_q : 32'h0;
                state_d = ST_REQ;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
        sel_d   = cyc_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            beat_q      <= 1'b0;
            cnt_q       <= '0;
            wide_q      <= 1'b0;
            region_q    <= RGN_MODE;
            idx_q       <= '0;
            hi_q        <= '0;
            ready_q     <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            wide_q      <= wide_d;
            region_q    <= region_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wbm_patch_master.sv
module tb_wbm_patch_master;
    import wbm_patch_master_pkg::*;

    localparam int IDX_W = 24;
    localparam int TO    = 12;

    typedef struct {
        logic        we;
        logic [2:0]  region;
        logic        wide;
        logic [23:0] idx;
        logic [63:0] wdata;
        int          dly;    // slave ack delay in stb cycles, 0 = never ack
        int          hold;   // cycles rsp_ready is held low
    } cmd_t;

    typedef struct {
        int              nb;
        logic [1:0][31:0] adr;
        logic [1:0][31:0] dat;
        logic [63:0]     rdata;
        logic            err;
    } exp_t;

    typedef struct {
        cmd_t c;
        exp_t e;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          start;
        int          endc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbm_patch_master_if #(.IDX_W(IDX_W)) bus ();

    wbm_patch_master #(.IDX_W(IDX_W), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- slave model ----------------
    logic [31:0] rd_ovr [logic [31:0]];
    beat_t       blog[$];
    bit          ack_on  = 1'b1;
    int          ack_dly = 1;
    bit          spur    = 1'b0;
    int          cyc_n   = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (rd_ovr.exists(a)) return rd_ovr[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        bit prev;
        int wcnt;
        beat_t bt;
        prev = 1'b0;
        wcnt = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (bus.wbm_cyc_o && !prev) begin
                bt.adr = bus.wbm_adr_o; bt.dat = bus.wbm_dat_o; bt.we = bus.wbm_we_o;
                bt.start = cyc_n; bt.endc = -1;
                blog.push_back(bt);
                chk("beat.stb_eq_cyc", {63'h0, bus.wbm_stb_o}, 64'h1);
                chk("beat.sel", {60'h0, bus.wbm_sel_o}, 64'hF);
            end
            if (!bus.wbm_cyc_o && prev) blog[$].endc = cyc_n;
            prev = bus.wbm_cyc_o;
            if (bus.wbm_ack_i) begin
                bus.wbm_ack_i = 1'b0;
                wcnt = 0;
            end else if (bus.wbm_cyc_o) begin
                wcnt++;
                if (ack_on && wcnt >= ack_dly) begin
                    bus.wbm_ack_i = 1'b1;
                    bus.wbm_dat_i = rd_word(bus.wbm_adr_o);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
            if (spur) begin
                bus.wbm_ack_i = 1'b1;
                bus.wbm_dat_i = 32'hFFFF_FFFF;
                spur = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_base(input logic [2:0] r);
        case (r)
            3'd2:    return 32'h3100_0000;
            3'd3:    return 32'h3200_0000;
            3'd4:    return 32'h3300_0000;
            3'd5:    return 32'h3400_0000;
            default: return 32'h3000_0000;
        endcase
    endfunction

    function automatic exp_t model(input cmd_t c);
        exp_t   e;
        longint off;
        logic [31:0] a;
        e.nb = 0; e.adr = '0; e.dat = '0; e.rdata = '0; e.err = 1'b0;
        for (int b = 0; b < (c.wide ? 2 : 1); b++) begin
            off = c.wide ? longint'(c.idx) * 2 + b : longint'(c.idx);
            off = off % (longint'(1) << 24);
            a = ref_base(c.region) + 32'(off);
            e.nb = b + 1;
            e.adr[b] = a;
            e.dat[b] = c.we ? c.wdata[b*32 +: 32] : 32'h0;
            if (c.dly == 0 || c.dly > TO) begin
                e.err = 1'b1;
                break;
            end
            if (!c.we) e.rdata[b*32 +: 32] = rd_word(a);
        end
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic issue_cmd(input cmd_t c, input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk({tag, ".ready_wait"}, 64'h1, 64'h0); return; end
        ack_on  = (c.dly != 0);
        ack_dly = c.dly;
        bus.cmd_we     = c.we;
        bus.cmd_region = wb_region_t'(c.region);
        bus.cmd_wide   = c.wide;
        bus.cmd_index  = c.idx;
        bus.cmd_wdata  = c.wdata;
        bus.cmd_valid  = 1'b1;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
        chk({tag, ".ready_after_accept"}, {63'h0, bus.cmd_ready}, 64'h0);
    endtask

    task automatic wait_rsp(input int hold, input string tag, output logic [63:0] rd, output logic err);
        int n = 0;
        bit bad = 1'b0;
        rd = 'x; err = 1'bx;
        while (bus.rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin chk({tag, ".rsp_wait"}, 64'h1, 64'h0); return; end
        rd = bus.rsp_rdata;
        err = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd || bus.rsp_err !== err ||
                bus.cmd_ready !== 1'b0 || bus.wbm_cyc_o !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) chk({tag, ".hold_stable"}, {63'h0, bad}, 64'h0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, {63'h0, bus.rsp_valid}, 64'h0);
        chk({tag, ".ready_resume"}, {63'h0, bus.cmd_ready}, 64'h1);
    endtask

    task automatic run(input cmd_t c, input exp_t e, input string tag);
        int first, nact, elen;
        logic [63:0] rd;
        logic        err;
        first = blog.size();
        issue_cmd(c, tag);
        wait_rsp(c.hold, tag, rd, err);
        nact = blog.size() - first;
        elen = (c.dly == 0 || c.dly > TO) ? TO : c.dly;
        chk({tag, ".nbeats"}, 64'(nact), 64'(e.nb));
        for (int b = 0; b < e.nb && b < nact; b++) begin
            chk($sformatf("%s.b%0d.adr", tag, b), {32'h0, blog[first+b].adr}, {32'h0, e.adr[b]});
            chk($sformatf("%s.b%0d.we", tag, b), {63'h0, blog[first+b].we}, {63'h0, c.we});
            if (c.we) chk($sformatf("%s.b%0d.dat", tag, b), {32'h0, blog[first+b].dat}, {32'h0, e.dat[b]});
            if (b == e.nb - 1)
                chk($sformatf("%s.b%0d.len", tag, b), 64'(blog[first+b].endc - blog[first+b].start), 64'(elen));
            if (b == 1)
                chk({tag, ".gap"}, 64'(blog[first+1].start - blog[first].endc), 64'd1);
        end
        chk({tag, ".rdata"}, rd, e.rdata);
        chk({tag, ".err"}, {63'h0, err}, {63'h0, e.err});
    endtask

    function automatic vec_t mkv(input logic we, input logic [2:0] rg, input logic wide,
                                 input logic [23:0] idx, input logic [63:0] wd, input int dly,
                                 input int hold, input int nb, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [63:0] rdata, input logic err);
        vec_t v;
        v.c.we = we; v.c.region = rg; v.c.wide = wide; v.c.idx = idx; v.c.wdata = wd;
        v.c.dly = dly; v.c.hold = hold;
        v.e.nb = nb; v.e.adr[0] = a0; v.e.dat[0] = d0; v.e.adr[1] = a1; v.e.dat[1] = d1;
        v.e.rdata = rdata; v.e.err = err;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        cmd_t c;
        int   first, n;
        bit   seen;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_region = RGN_MODE;
        bus.cmd_wide = 1'b0; bus.cmd_index = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
        rd_ovr[32'h3200_0026] = 32'hAAAA_0001;
        rd_ovr[32'h3200_0027] = 32'h5555_0002;

        //        we  rg    wd  idx         wdata                  dly    hold nb adr0          dat0          adr1          dat1          rdata                  err
        vecs.push_back(mkv(1, 3'd2, 1, 24'h5,      64'h0012_3456_789A_BCDE, 2,     0, 2, 32'h3100_000A, 32'h789A_BCDE, 32'h3100_000B, 32'h0012_3456, 64'h0, 0));
        vecs.push_back(mkv(0, 3'd3, 1, 24'h13,     64'h0,                   3,     0, 2, 32'h3200_0026, 32'h0,         32'h3200_0027, 32'h0,         64'h5555_0002_AAAA_0001, 0));
        vecs.push_back(mkv(1, 3'd0, 0, 24'h0,      64'h1,                   2,     0, 1, 32'h3000_0000, 32'h1,         32'h0,         32'h0,         64'h0, 0));
        vecs.push_back(mkv(1, 3'd1, 0, 24'h1,      64'hDEAD_BEEF_CAFE_F00D, 1,     0, 1, 32'h3000_0001, 32'hCAFE_F00D, 32'h0,         32'h0,         64'h0, 0));
        vecs.push_back(mkv(1, 3'd4, 1, 24'h7,      64'h1234_5678_9ABC_DEF0, 0,     0, 1, 32'h3300_000E, 32'h9ABC_DEF0, 32'h0,         32'h0,         64'h0, 1));
        vecs.push_back(mkv(0, 3'd5, 0, 24'h42,     64'h0,                   1,    10, 1, 32'h3400_0042, 32'h0,         32'h0,         32'h0,         64'h0000_0000_6E5A_5A18, 0));
        vecs.push_back(mkv(1, 3'd5, 1, 24'hFFFFFF, 64'h1111_2222_3333_4444, 2,     0, 2, 32'h34FF_FFFE, 32'h3333_4444, 32'h34FF_FFFF, 32'h1111_2222, 64'h0, 0));
        vecs.push_back(mkv(0, 3'd2, 0, 24'h123456, 64'h0,                   TO,    0, 1, 32'h3112_3456, 32'h0,         32'h0,         32'h0,         64'h0000_0000_6B48_6E0C, 0));
        vecs.push_back(mkv(0, 3'd3, 0, 24'h3,      64'h0,                   TO+1,  0, 1, 32'h3200_0003, 32'h0,         32'h0,         32'h0,         64'h0, 1));
        vecs.push_back(mkv(0, 3'd1, 1, 24'h1,      64'h0,                   4,     2, 2, 32'h3000_0002, 32'h0,         32'h3000_0003, 32'h0,         64'h6A5A_5A59_6A5A_5A58, 0));

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset.cyc", {63'h0, bus.wbm_cyc_o}, 64'h0);
        chk("reset.stb", {63'h0, bus.wbm_stb_o}, 64'h0);
        chk("reset.we", {63'h0, bus.wbm_we_o}, 64'h0);
        chk("reset.sel", {60'h0, bus.wbm_sel_o}, 64'h0);
        chk("reset.adr", {32'h0, bus.wbm_adr_o}, 64'h0);
        chk("reset.dat", {32'h0, bus.wbm_dat_o}, 64'h0);
        chk("reset.rsp_valid", {63'h0, bus.rsp_valid}, 64'h0);
        chk("reset.rdata", bus.rsp_rdata, 64'h0);
        chk("reset.err", {63'h0, bus.rsp_err}, 64'h0);
        chk("reset.cmd_ready", {63'h0, bus.cmd_ready}, 64'h1);

        foreach (vecs[i]) run(vecs[i].c, vecs[i].e, $sformatf("vec%0d", i));

        // reset pulse while beat1 of a wide write is on the bus
        c.we = 1; c.region = 3'd2; c.wide = 1; c.idx = 24'h9; c.wdata = 64'hA5A5_A5A5_5A5A_5A5A;
        c.dly = 3; c.hold = 0;
        first = blog.size();
        issue_cmd(c, "rst_mid");
        n = 0;
        while (blog.size() < first + 2 && n < 100) begin @(negedge clk); n++; end
        chk("rst_mid.beat1_started", 64'(blog.size() - first), 64'd2);
        ack_on = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.cyc", {63'h0, bus.wbm_cyc_o}, 64'h0);
        chk("rst_mid.stb", {63'h0, bus.wbm_stb_o}, 64'h0);
        chk("rst_mid.cmd_ready", {63'h0, bus.cmd_ready}, 64'h1);
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) seen = 1'b1; end
        chk("rst_mid.no_rsp", {63'h0, seen}, 64'h0);
        spur = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || bus.cmd_ready !== 1'b1) seen = 1'b1;
        end
        chk("spur_ack.no_effect", {63'h0, seen}, 64'h0);
        chk("spur_ack.no_beats", 64'(blog.size() - first), 64'd2);

        // randomized commands against the reference model
        for (int k = 0; k < 40; k++) begin
            int r;
            c.we     = 1'($urandom_range(0, 1));
            c.region = 3'($urandom_range(0, 5));
            c.wide   = 1'($urandom_range(0, 1));
            c.idx    = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 255));
            c.wdata  = {$urandom, $urandom};
            r        = int'($urandom_range(0, 9));
            c.dly    = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO : int'($urandom_range(1, 4));
            c.hold   = int'($urandom_range(0, 2));
            run(c, model(c), $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
